dh_responder: RTL
=================

Name: dh_responder

Overview:
Responder side of the Diffie-Hellman exchange. It accepts the initiator's public value, then computes and hands back its own public value g^priv mod p. After that it computes the shared secret peer_pub^priv mod p. Both exponentiations share one internal constant-time, right-to-left square-and-multiply engine that processes one exponent bit per clock. The block sits between the link-side message interface and the key-store.

Parameters:
WIDTH, 32, bit width of modulus, generator, keys and results.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
peer_valid  in  1  peer public value and session operands are valid
peer_ready  out  1  block can accept a new session (registered)
peer_pub  in  WIDTH  initiator public value A
priv_key  in  WIDTH  responder private exponent
gen  in  WIDTH  generator g
modulus  in  WIDTH  prime p
pub_valid  out  1  pub_key is valid and waiting for pickup
pub_ready  in  1  downstream takes pub_key
pub_key  out  WIDTH  g^priv mod p
secret  out  WIDTH  A^priv mod p
secret_valid  out  1  one-cycle pulse when secret is updated
err  out  1  one-cycle pulse when a session is rejected
busy  out  1  high from accept until DONE/ERR completes

Behaviour:
- Reset (rst low, asynchronous): state=IDLE.
  - peer_ready=0, pub_valid=0, secret_valid=0, err=0, busy=0, pub_key=0, secret=0.
  - On the first clk edge after rst rises: peer_ready=1.
- States: IDLE, CHECK, EXP_PUB, SEND_PUB, EXP_SEC, DONE, ERR.
- IDLE:
  - peer_ready=1.
  - On an edge with peer_valid&peer_ready (accept edge t0): latch peer_pub, priv_key, gen and modulus into internal registers.
  - At the same edge: peer_ready->0, busy->1, go to CHECK.
  - Input changes after t0 have no effect on the session.
- CHECK (one cycle, decided at edge t0+1). The session is rejected if any of the following holds:
  - modulus<3 or modulus even;
  - gen<2 or gen>=modulus;
  - peer_pub<2 or peer_pub>modulus-2.
  - Reject -> ERR. Accept -> EXP_PUB with acc=1, base=gen, exponent shift register=priv_key, bit counter=0.
- ERR (one cycle):
  - err=1 for exactly one cycle.
  - busy->0 and peer_ready->1 at the following edge; back to IDLE.
  - pub_key and secret keep their previous values.
- EXP_PUB / EXP_SEC: exactly WIDTH iterations, one per edge, independent of exponent value (constant time).
  - Each iteration: if the current exponent LSB=1, acc=(acc*base) mod modulus.
  - Each iteration also: base=(base*base) mod modulus, exponent>>=1, counter+1.
  - Products are full 2*WIDTH bits before reduction. Intermediate values are always < modulus.
  - priv_key=0 yields result 1.
- End of EXP_PUB (edge t0+WIDTH+1):
  - pub_key<=acc, pub_valid<=1, go to SEND_PUB.
- SEND_PUB:
  - pub_valid held high and pub_key stable until an edge with pub_ready=1 (handshake edge th).
  - At th: pub_valid->0; reload acc=1, base=peer_pub, exponent=priv_key; go to EXP_SEC.
  - pub_ready while pub_valid=0 is ignored.
- End of EXP_SEC (edge th+WIDTH):
  - secret<=acc, secret_valid=1 for one cycle, go to DONE.
- DONE (one cycle): busy->0, peer_ready->1, return to IDLE.
  - pub_key and secret hold until overwritten by a later successful session.
- peer_valid while peer_ready=0 is ignored; no queueing.
- Reset asserted mid-operation aborts immediately to the reset values. No partial result is exposed.
- Latency with pub_ready tied high:
  - pub_valid high after edge t0+WIDTH+1;
  - th=t0+WIDTH+2;
  - secret_valid pulse after edge t0+2*WIDTH+2 (t0+66 for WIDTH=32).

Test Plan:
1. Nominal exchange: p=23, g=5, priv=6, A=19, pub_ready tied 1 -> pub_key=8 with pub_valid at t0+33; secret=2 with a one-cycle secret_valid at t0+66; err never asserted; peer_ready high again the cycle after DONE.
2. Backpressure: same operands, pub_ready held 0 for 10 cycles after pub_valid rises -> pub_valid and pub_key=8 stay stable throughout; secret_valid occurs exactly WIDTH edges after the handshake edge; secret=2.
3. Invalid inputs -> single err pulse at t0+1, no pub_valid, no secret_valid, pub_key/secret unchanged, peer_ready=1 two edges after t0. Cases: A=1; A=22 with p=23; g=23; p=22; p=2.
4. Edge exponents, with p=23, g=5, A=19:
   - priv=0 -> pub_key=1, secret=1;
   - priv=0xFFFFFFFF -> pub_key and secret match a software modular-exponentiation model;
   - latency identical to scenario 1.
5. Busy protection and reset: pulse peer_valid with new operands during EXP_PUB -> ignored, results are from the first session. Then assert rst during EXP_SEC -> all outputs at reset values immediately, and a fresh session afterwards completes correctly.
6. Randomised: 200 sessions with random odd p<2^32 and legal g/A/priv, random pub_ready stalls -> every pub_key/secret matches the reference model; secret_valid exactly once per accepted session.

Source files
------------

// File: rtl/dh_responder.sv
// Diffie-Hellman responder.
// Accepts an initiator public value plus session operands, returns g^priv mod p
// through a valid/ready handshake, then computes the shared secret
// peer_pub^priv mod p. Both exponentiations run on one right-to-left
// square-and-multiply engine that consumes one exponent bit per clock. Every
// exponentiation always takes WIDTH clocks, whatever the exponent value.
module dh_responder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             peer_valid,
    output logic             peer_ready,
    input  logic [WIDTH-1:0] peer_pub,
    input  logic [WIDTH-1:0] priv_key,
    input  logic [WIDTH-1:0] gen,
    input  logic [WIDTH-1:0] modulus,
    output logic             pub_valid,
    input  logic             pub_ready,
    output logic [WIDTH-1:0] pub_key,
    output logic [WIDTH-1:0] secret,
    output logic             secret_valid,
    output logic             err,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [WIDTH-1:0] VAL_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] VAL_TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0] VAL_THREE = WIDTH'(3);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CHECK    = 3'd1;
    localparam logic [2:0] S_EXP_PUB  = 3'd2;
    localparam logic [2:0] S_SEND_PUB = 3'd3;
    localparam logic [2:0] S_EXP_SEC  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;
    localparam logic [2:0] S_ERR      = 3'd6;

    // (a*b) mod m on the full double-width product. A zero modulus can only
    // appear on an unused cycle (sessions with m<3 are rejected), so it
    // simply yields zero instead of an undefined division.
    function automatic logic [WIDTH-1:0] mod_mul(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] m
    );
        logic [2*WIDTH-1:0] prod;
        logic [2*WIDTH-1:0] rem;
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        if (m == '0) begin
            rem = '0;
        end else begin
            rem = prod % {{WIDTH{1'b0}}, m};
        end
        return rem[WIDTH-1:0];
    endfunction

    // A session is unusable when the modulus cannot be an odd prime >= 3,
    // the generator is outside [2, p-1], or the peer value is outside
    // [2, p-2] (which excludes the degenerate values 0, 1 and p-1).
    function automatic logic session_bad(
        input logic [WIDTH-1:0] p,
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] a
    );
        logic bad_p;
        logic bad_g;
        logic bad_a;
        bad_p = (p < VAL_THREE) || !p[0];
        bad_g = (g < VAL_TWO) || (g >= p);
        bad_a = (a < VAL_TWO) || (a > (p - VAL_TWO));
        return bad_p || bad_g || bad_a;
    endfunction

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] peer_pub_r;
    logic [WIDTH-1:0] priv_r;
    logic [WIDTH-1:0] gen_r;
    logic [WIDTH-1:0] mod_r;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] expo;

    logic [WIDTH-1:0] acc_mul;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] base_next;
    logic             accept;
    logic             last_iter;
    logic             reject;

    assign accept    = peer_valid && peer_ready;
    assign last_iter = (cnt == CNT_LAST);
    assign reject    = session_bad(mod_r, gen_r, peer_pub_r);

    // One square-and-multiply step: both products are formed every cycle and
    // the exponent bit only selects, so timing does not depend on the key.
    always_comb begin
        acc_mul   = mod_mul(acc, base, mod_r);
        base_next = mod_mul(base, base, mod_r);
        acc_next  = expo[0] ? acc_mul : acc;
    end

    // Operand capture and exponentiation datapath; its contents only matter
    // while the control FSM says so, so it carries no reset.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                if (accept) begin
                    peer_pub_r <= peer_pub;
                    priv_r     <= priv_key;
                    gen_r      <= gen;
                    mod_r      <= modulus;
                end
            end
            S_CHECK: begin
                acc  <= VAL_ONE;
                base <= gen_r;
                expo <= priv_r;
            end
            S_EXP_PUB, S_EXP_SEC: begin
                acc  <= acc_next;
                base <= base_next;
                expo <= expo >> 1;
            end
            S_SEND_PUB: begin
                if (pub_ready && pub_valid) begin
                    acc  <= VAL_ONE;
                    base <= peer_pub_r;
                    expo <= priv_r;
                end
            end
            default: begin
            end
        endcase
    end

    // Session control FSM, handshake flags and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            peer_ready   <= 1'b0;
            pub_valid    <= 1'b0;
            secret_valid <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
            pub_key      <= '0;
            secret       <= '0;
        end else begin
            err          <= 1'b0;
            secret_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    peer_ready <= 1'b1;
                    if (accept) begin
                        peer_ready <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    cnt <= '0;
                    if (reject) begin
                        err   <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        state <= S_EXP_PUB;
                    end
                end
                S_EXP_PUB: begin
                    cnt <= cnt + CNT_ONE;
                    if (last_iter) begin
                        pub_key   <= acc_next;
                        pub_valid <= 1'b1;
                        state     <= S_SEND_PUB;
                    end
                end
                S_SEND_PUB: begin
                    if (pub_ready && pub_valid) begin
                        pub_valid <= 1'b0;
                        cnt       <= '0;
                        state     <= S_EXP_SEC;
                    end
                end
                S_EXP_SEC: begin
                    cnt <= cnt + CNT_ONE;
                    if (last_iter) begin
                        secret       <= acc_next;
                        secret_valid <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DONE, S_ERR: begin
                    busy       <= 1'b0;
                    peer_ready <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    busy       <= 1'b0;
                    peer_ready <= 1'b0;
                    pub_valid  <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
